axi_lite_spi_regif: RTL

AXI_LITE_SPI_REGIF -- requirements
Module: axi_lite_spi_regif

---
 rtl/axi_lite_spi_regif.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_spi_regif.sv
// AXI4-Lite slave front end for the SPI controller: decodes four word registers
// and turns bus writes/reads into one-cycle strobes toward the controller.
module axi_lite_spi_regif #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       o_data_to_registers,
  output logic              o_wr_controll_reg,
  output logic              o_wr_data_reg,
  output logic              o_read_status_reg,
  input  logic [31:0]       i_controll_reg,
  input  logic [31:0]       i_status_reg,
  input  logic [31:0]       i_data_reg
);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_VALID} rstate_e;

  localparam logic [1:0] SEL_CTRL   = 2'd0;
  localparam logic [1:0] SEL_STATUS = 2'd1;
  localparam logic [1:0] SEL_DATA   = 2'd2;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLV   = 2'b10;

  wstate_e     w_state_q;
  logic [1:0]  awsel_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q;
  logic        wr_ctrl_q, wr_data_q;
  logic [31:0] data_out_q;

  rstate_e     r_state_q;
  logic        arready_q, rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        aw_hs, w_hs, ar_hs, have_aw, have_w, wr_err_d;
  logic [1:0]  wsel_d, rsel_d;
  logic [31:0] wdata_d, rdata_d;
  logic [3:0]  wstrb_d;
  logic        unused_bits;

  // Only address bits [3:2] and strobe bit 0 matter to the decode.
  assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_wstrb[3:1]};

  assign aw_hs   = s_axi_awvalid & awready_q;
  assign w_hs    = s_axi_wvalid & wready_q;
  assign ar_hs   = s_axi_arvalid & arready_q;
  assign have_aw = aw_hs | (w_state_q == W_HAVE_ADDR);
  assign have_w  = w_hs | (w_state_q == W_HAVE_DATA);
  assign rsel_d  = s_axi_araddr[3:2];

  // The beat that arrived earlier comes from the latch, the other straight from the bus.
  always_comb begin
    wsel_d  = (w_state_q == W_HAVE_ADDR) ? awsel_q : s_axi_awaddr[3:2];
    wdata_d = (w_state_q == W_HAVE_DATA) ? wdata_q : s_axi_wdata;
    wstrb_d = (w_state_q == W_HAVE_DATA) ? wstrb_q : s_axi_wstrb;
    // Status (01) and the hole at 0x0C (11) both have bit 0 set.
    wr_err_d = wsel_d[0] | ~wstrb_d[0];
  end

  always_comb begin
    rdata_d = 32'd0;
    case (rsel_d)
      SEL_CTRL:   rdata_d = i_controll_reg;
      SEL_STATUS: rdata_d = i_status_reg;
      SEL_DATA:   rdata_d = i_data_reg;
      default:    rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      w_state_q  <= W_IDLE;
      awsel_q    <= 2'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_ctrl_q  <= 1'b0;
      wr_data_q  <= 1'b0;
      data_out_q <= 32'd0;
    end else begin
      wr_ctrl_q  <= 1'b0;
      wr_data_q  <= 1'b0;
      data_out_q <= 32'd0;
      case (w_state_q)
        W_IDLE, W_HAVE_ADDR, W_HAVE_DATA: begin
          if (aw_hs) awsel_q <= s_axi_awaddr[3:2];
          if (w_hs) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
          end
          if (have_aw && have_w) begin
            w_state_q <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_err_d ? RESP_SLV : RESP_OKAY;
            if (!wr_err_d) begin
              wr_ctrl_q  <= (wsel_d == SEL_CTRL);
              wr_data_q  <= (wsel_d == SEL_DATA);
              data_out_q <= wdata_d;
            end
          end else if (have_aw) begin
            w_state_q <= W_HAVE_ADDR;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
          end else if (have_w) begin
            w_state_q <= W_HAVE_DATA;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
          end else begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            r_state_q <= R_VALID;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rdata_d;
            rresp_q   <= (rsel_d == 2'd3) ? RESP_SLV : RESP_OKAY;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_VALID: begin
          if (s_axi_rready) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign s_axi_awready       = awready_q;
  assign s_axi_wready        = wready_q;
  assign s_axi_bvalid        = bvalid_q;
  assign s_axi_bresp         = bresp_q;
  assign s_axi_arready       = arready_q;
  assign s_axi_rvalid        = rvalid_q;
  assign s_axi_rdata         = rdata_q;
  assign s_axi_rresp         = rresp_q;
  assign o_wr_controll_reg   = wr_ctrl_q;
  assign o_wr_data_reg       = wr_data_q;
  assign o_data_to_registers = data_out_q;
  // Status flags are cleared by the controller on the very handshake cycle.
  assign o_read_status_reg   = ar_hs & (rsel_d == SEL_STATUS);

endmodule
